// File: rtl/axi_w_order_sched.sv
// axi_w_order_sched: shares one downstream AXI W path among NUM_SLAVES
// upstream write ports, forwarding W bursts strictly in AW grant order.
// The AW arbiter pushes the granted port index into an order FIFO; the head
// entry selects which port is routed until its last beat, then it is popped.
// Optional feature macro: AXI_W_ORDER_SCHED_BEAT_CHECK_EN builds a 9-bit beat
// counter that flags a burst running 256 beats without last on err_o.
module axi_w_order_sched #(
  parameter int NUM_SLAVES  = 2,
  parameter int DATA_WIDTH  = 64,
  parameter int USER_WIDTH  = 1,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int ORDER_DEPTH = 4,
  parameter int SEL_WIDTH   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             aw_push_valid_i,
  input  logic [SEL_WIDTH-1:0]             aw_push_sel_i,
  output logic                             aw_push_ready_o,
  input  logic [NUM_SLAVES-1:0]            slave_valid_i,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_data_i,
  input  logic [NUM_SLAVES*STRB_WIDTH-1:0] slave_strb_i,
  input  logic [NUM_SLAVES*USER_WIDTH-1:0] slave_user_i,
  input  logic [NUM_SLAVES-1:0]            slave_last_i,
  output logic [NUM_SLAVES-1:0]            slave_ready_o,
  output logic                             master_valid_o,
  output logic [DATA_WIDTH-1:0]            master_data_o,
  output logic [STRB_WIDTH-1:0]            master_strb_o,
  output logic [USER_WIDTH-1:0]            master_user_o,
  output logic                             master_last_o,
  input  logic                             master_ready_i,
  output logic [$clog2(ORDER_DEPTH):0]     outstanding_o,
  output logic                             err_o
);

  localparam int PTR_W = $clog2(ORDER_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } state_e;

  logic [SEL_WIDTH-1:0] fifo_q [ORDER_DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  state_e               state_q, state_d;
  logic                 err_q, err_d;

  logic                 full_s;
  logic                 sel_ok_s;
  logic                 push_hs_s;
  logic                 push_wr_s;
  logic                 route_s;
  logic                 beat_hs_s;
  logic                 pop_s;
  logic                 beat_err_s;
  logic [SEL_WIDTH-1:0] head_s;

  // A full FIFO never accepts, even when it pops in the same cycle (no bypass).
  assign full_s          = (count_q == CNT_W'(ORDER_DEPTH));
  assign aw_push_ready_o = ~full_s & ~rst_i;
  assign push_hs_s       = aw_push_valid_i & aw_push_ready_o;
  // Widen before comparing so NUM_SLAVES == 2**SEL_WIDTH does not truncate.
  assign sel_ok_s        = ({1'b0, aw_push_sel_i} < (SEL_WIDTH+1)'(NUM_SLAVES));
  assign push_wr_s       = push_hs_s & sel_ok_s;
  assign head_s          = fifo_q[rd_ptr_q];
  assign route_s         = (state_q == ROUTE) & ~rst_i;
  assign beat_hs_s       = route_s & master_valid_o & master_ready_i;
  assign pop_s           = beat_hs_s & master_last_o;
  assign outstanding_o   = count_q;
  assign err_o           = err_q;

  // Combinational W mux: the head port drives downstream, all others stall.
  always_comb begin
    master_valid_o = 1'b0;
    master_data_o  = '0;
    master_strb_o  = '0;
    master_user_o  = '0;
    master_last_o  = 1'b0;
    slave_ready_o  = '0;
    if (route_s) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (head_s == SEL_WIDTH'(i)) begin
          master_valid_o   = slave_valid_i[i];
          master_data_o    = slave_data_i[i*DATA_WIDTH +: DATA_WIDTH];
          master_strb_o    = slave_strb_i[i*STRB_WIDTH +: STRB_WIDTH];
          master_user_o    = slave_user_i[i*USER_WIDTH +: USER_WIDTH];
          master_last_o    = slave_last_i[i];
          slave_ready_o[i] = master_ready_i;
        end else begin
          slave_ready_o[i] = 1'b0;
        end
      end
    end else begin
      slave_ready_o = '0;
    end
  end

  // Order FIFO pointer/occupancy update and burst-state next-state logic.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (push_wr_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_wr_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    case (state_q)
      IDLE: begin
        if (push_wr_s) begin
          state_d = ROUTE;
        end else begin
          state_d = IDLE;
        end
      end
      ROUTE: begin
        if (pop_s && (count_d == CNT_W'(0))) begin
          state_d = IDLE;
        end else begin
          state_d = ROUTE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef AXI_W_ORDER_SCHED_BEAT_CHECK_EN
  logic [8:0] beat_q, beat_d;

  // Beat counter: flags the 256th handshake of a burst that has not ended.
  always_comb begin
    beat_d     = beat_q;
    beat_err_s = 1'b0;
    if (beat_hs_s) begin
      if (master_last_o) begin
        beat_d = 9'd0;
      end else begin
        if (beat_q == 9'd255) begin
          beat_err_s = 1'b1;
        end else begin
          beat_err_s = 1'b0;
        end
        if (beat_q != 9'h1FF) begin
          beat_d = beat_q + 9'd1;
        end else begin
          beat_d = beat_q;
        end
      end
    end else begin
      beat_d = beat_q;
    end
  end

  // Beat counter register; reset aborts any burst in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q <= 9'd0;
    end else begin
      beat_q <= beat_d;
    end
  end
`else
  assign beat_err_s = 1'b0;
`endif

  // Sticky error: invalid pushed index or runaway burst.
  always_comb begin
    err_d = err_q | (push_hs_s & ~sel_ok_s) | beat_err_s;
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      err_q    <= err_d;
    end
  end

  // Order storage; entries are only meaningful between write and read pointer.
  always_ff @(posedge clk_i) begin
    if (push_wr_s) begin
      fifo_q[wr_ptr_q] <= aw_push_sel_i;
    end
  end

endmodule

// File: tb/tb_axi_w_order_sched.sv
// Self-checking bench for axi_w_order_sched (3 ports, 16-bit data, depth 4).
module tb_axi_w_order_sched;

  localparam int NS = 3;
  localparam int DW = 16;
  localparam int SW = 2;
  localparam int UW = 1;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic           aw_push_valid_i = 1'b0;
  logic [1:0]     aw_push_sel_i = 2'd0;
  logic           aw_push_ready_o;
  logic [NS-1:0]  slave_valid_i = '0;
  logic [NS*DW-1:0] slave_data_i = '0;
  logic [NS*SW-1:0] slave_strb_i = '0;
  logic [NS*UW-1:0] slave_user_i = '0;
  logic [NS-1:0]  slave_last_i = '0;
  logic [NS-1:0]  slave_ready_o;
  logic           master_valid_o;
  logic [DW-1:0]  master_data_o;
  logic [SW-1:0]  master_strb_o;
  logic [UW-1:0]  master_user_o;
  logic           master_last_o;
  logic           master_ready_i = 1'b0;
  logic [2:0]     outstanding_o;
  logic           err_o;

  axi_w_order_sched #(
    .NUM_SLAVES (NS),
    .DATA_WIDTH (DW),
    .USER_WIDTH (UW),
    .STRB_WIDTH (SW),
    .ORDER_DEPTH(4)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .aw_push_valid_i(aw_push_valid_i),
    .aw_push_sel_i  (aw_push_sel_i),
    .aw_push_ready_o(aw_push_ready_o),
    .slave_valid_i  (slave_valid_i),
    .slave_data_i   (slave_data_i),
    .slave_strb_i   (slave_strb_i),
    .slave_user_i   (slave_user_i),
    .slave_last_i   (slave_last_i),
    .slave_ready_o  (slave_ready_o),
    .master_valid_o (master_valid_o),
    .master_data_o  (master_data_o),
    .master_strb_o  (master_strb_o),
    .master_user_o  (master_user_o),
    .master_last_o  (master_last_o),
    .master_ready_i (master_ready_i),
    .outstanding_o  (outstanding_o),
    .err_o          (err_o)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]  port;
    logic [15:0] data;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic       aw_v;
    logic [1:0] aw_sel;
    logic [2:0] sv;
    logic [2:0] sl;
    logic       mr;
    logic       mv;
    logic [2:0] sr;
    logic       ml;
    logic [2:0] outs;
    logic       awr;
    logic [15:0] md;
  } vec_t;

  int errors = 0;
  int checks = 0;

  beat_t      src_q [NS][$];
  beat_t      exp_q [$];
  logic [1:0] aw_pend_sel [$];
  int         aw_pend_n [$];
  bit         aw_acc = 1'b0;
  bit         pop_pend = 1'b0;
  bit         err_pend = 1'b0;
  bit         err_m = 1'b0;
  bit         mready = 1'b0;
  int         occ = 0;
  int         run_cnt = 0;
  int         burst_id = 0;
  vec_t       vt [8];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic make_burst(input int p, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.port = 2'(p);
      b.data = {4'(p), 4'(burst_id), 8'(k)};
      b.last = (k == n - 1);
      src_q[p].push_back(b);
      exp_q.push_back(b);
    end
    burst_id++;
  endtask

  task automatic queue_aw(input logic [1:0] sel, input int n);
    aw_pend_sel.push_back(sel);
    aw_pend_n.push_back(n);
  endtask

  task automatic clear_model();
    exp_q.delete();
    aw_pend_sel.delete();
    aw_pend_n.delete();
    aw_acc = 1'b0;
    pop_pend = 1'b0;
    err_pend = 1'b0;
    err_m = 1'b0;
    occ = 0;
    run_cnt = 0;
  endtask

  // Applies effects of the edge just passed, then drives the next inputs.
  task automatic drive_phase();
    if (pop_pend) begin
      occ--;
      pop_pend = 1'b0;
    end
    if (err_pend) begin
      err_m = 1'b1;
      err_pend = 1'b0;
    end
    if (aw_acc) begin
      if (aw_pend_sel[0] < 2'd3) begin
        occ++;
        make_burst(int'(aw_pend_sel[0]), aw_pend_n[0]);
      end else begin
        err_m = 1'b1;
      end
      void'(aw_pend_sel.pop_front());
      void'(aw_pend_n.pop_front());
      aw_acc = 1'b0;
    end
    aw_push_valid_i = (aw_pend_sel.size() > 0);
    aw_push_sel_i   = aw_push_valid_i ? aw_pend_sel[0] : 2'd0;
    master_ready_i  = mready;
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() > 0) begin
        slave_valid_i[i]        = 1'b1;
        slave_data_i[i*DW +: DW] = src_q[i][0].data;
        slave_strb_i[i*SW +: SW] = src_q[i][0].data[1:0] ^ 2'b11;
        slave_user_i[i]         = ^src_q[i][0].data;
        slave_last_i[i]         = src_q[i][0].last;
      end else begin
        slave_valid_i[i]        = 1'b0;
        slave_data_i[i*DW +: DW] = '0;
        slave_strb_i[i*SW +: SW] = '0;
        slave_user_i[i]         = 1'b0;
        slave_last_i[i]         = 1'b0;
      end
    end
  endtask

  // Compares outputs against the model and consumes handshaken beats.
  task automatic monitor();
    logic         exp_mv;
    logic [NS-1:0] exp_sr;
    int           p;
    exp_mv = 1'b0;
    exp_sr = '0;
    if (exp_q.size() > 0) begin
      p = int'(exp_q[0].port);
      exp_mv = (src_q[p].size() > 0);
      exp_sr[p] = mready;
    end
    chk("master_valid", 32'(master_valid_o), 32'(exp_mv));
    chk("slave_ready", 32'(slave_ready_o), 32'(exp_sr));
    chk("outstanding", 32'(outstanding_o), 32'(occ));
    chk("aw_ready", 32'(aw_push_ready_o), 32'(occ < 4));
    chk("err", 32'(err_o), 32'(err_m));
    if (exp_q.size() == 0) begin
      chk("idle_data", 32'(master_data_o), 32'(0));
    end
    if (master_valid_o && master_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got data %0h expected no beat", master_data_o);
      end else begin
        chk("beat_data", 32'(master_data_o), 32'(exp_q[0].data));
        chk("beat_strb", 32'(master_strb_o), 32'(exp_q[0].data[1:0] ^ 2'b11));
        chk("beat_user", 32'(master_user_o), 32'(^exp_q[0].data));
        chk("beat_last", 32'(master_last_o), 32'(exp_q[0].last));
        if (exp_q[0].last) begin
          pop_pend = 1'b1;
          run_cnt = 0;
        end else begin
          run_cnt++;
`ifdef AXI_W_ORDER_SCHED_BEAT_CHECK_EN
          if (run_cnt == 256) err_pend = 1'b1;
`endif
        end
        void'(exp_q.pop_front());
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (slave_valid_i[i] && slave_ready_o[i] && src_q[i].size() > 0) begin
        void'(src_q[i].pop_front());
      end
    end
    aw_acc = aw_push_valid_i && aw_push_ready_o;
  endtask

  task automatic cycle();
    @(posedge clk_i); #1;
    drive_phase();
    @(negedge clk_i);
    monitor();
  endtask

  task automatic run_until_idle(input int limit);
    int n = 0;
    while ((exp_q.size() > 0 || aw_pend_sel.size() > 0 || aw_acc) && n < limit) begin
      cycle();
      n++;
    end
    if (n >= limit) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending beats expected 0", exp_q.size());
    end
    cycle();
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    aw_push_valid_i = 1'b0;
    slave_valid_i = '0;
    master_ready_i = 1'b0;
    @(negedge clk_i);
    chk("rst_aw_ready", 32'(aw_push_ready_o), 32'(0));
    chk("rst_mvalid", 32'(master_valid_o), 32'(0));
    chk("rst_sready", 32'(slave_ready_o), 32'(0));
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("rst_outstanding", 32'(outstanding_o), 32'(0));
    chk("rst_err", 32'(err_o), 32'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_aw_ready", 32'(aw_push_ready_o), 32'(1));
    chk("post_rst_mvalid", 32'(master_valid_o), 32'(0));
    chk("post_rst_sready", 32'(slave_ready_o), 32'(0));
    chk("post_rst_outstanding", 32'(outstanding_o), 32'(0));
    chk("post_rst_err", 32'(err_o), 32'(0));
    clear_model();
  endtask

  initial begin
    // Table: push sel=1 then a 4-beat burst from port 1 with constant data.
    vt[0] = '{1'b0, 2'd0, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 3'd0, 1'b1, 16'h0000};
    vt[1] = '{1'b1, 2'd1, 3'b010, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 3'd0, 1'b1, 16'h0000};
    vt[2] = '{1'b0, 2'd0, 3'b010, 3'b000, 1'b1, 1'b1, 3'b010, 1'b0, 3'd1, 1'b1, 16'hD001};
    vt[3] = '{1'b0, 2'd0, 3'b011, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0, 3'd1, 1'b1, 16'hD001};
    vt[4] = '{1'b0, 2'd0, 3'b011, 3'b000, 1'b1, 1'b1, 3'b010, 1'b0, 3'd1, 1'b1, 16'hD001};
    vt[5] = '{1'b0, 2'd0, 3'b010, 3'b000, 1'b1, 1'b1, 3'b010, 1'b0, 3'd1, 1'b1, 16'hD001};
    vt[6] = '{1'b0, 2'd0, 3'b010, 3'b010, 1'b1, 1'b1, 3'b010, 1'b1, 3'd1, 1'b1, 16'hD001};
    vt[7] = '{1'b0, 2'd0, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 3'd0, 1'b1, 16'h0000};

    do_reset();

    slave_data_i = {16'hD002, 16'hD001, 16'hD000};
    slave_strb_i = 6'b10_01_11;
    for (int v = 0; v < 8; v++) begin
      @(posedge clk_i); #1;
      aw_push_valid_i = vt[v].aw_v;
      aw_push_sel_i   = vt[v].aw_sel;
      slave_valid_i   = vt[v].sv;
      slave_last_i    = vt[v].sl;
      master_ready_i  = vt[v].mr;
      @(negedge clk_i);
      chk($sformatf("vec%0d_mvalid", v), 32'(master_valid_o), 32'(vt[v].mv));
      chk($sformatf("vec%0d_sready", v), 32'(slave_ready_o), 32'(vt[v].sr));
      chk($sformatf("vec%0d_mlast", v), 32'(master_last_o), 32'(vt[v].ml));
      chk($sformatf("vec%0d_outstanding", v), 32'(outstanding_o), 32'(vt[v].outs));
      chk($sformatf("vec%0d_aw_ready", v), 32'(aw_push_ready_o), 32'(vt[v].awr));
      chk($sformatf("vec%0d_mdata", v), 32'(master_data_o), 32'(vt[v].md));
    end
    slave_last_i = '0;

    // Ordered bursts 0,1,0 with port 1 data waiting early; no bubbles.
    mready = 1'b1;
    queue_aw(2'd0, 3);
    queue_aw(2'd1, 2);
    queue_aw(2'd0, 2);
    run_until_idle(60);

    // Fill the FIFO with no downstream progress, then pop while a 5th push waits.
    mready = 1'b0;
    queue_aw(2'd0, 1);
    queue_aw(2'd1, 1);
    queue_aw(2'd2, 1);
    queue_aw(2'd0, 1);
    queue_aw(2'd1, 1);
    for (int c = 0; c < 6; c++) cycle();
    chk("full_outstanding", 32'(outstanding_o), 32'(4));
    chk("full_aw_ready", 32'(aw_push_ready_o), 32'(0));
    mready = 1'b1;
    cycle();
    chk("fifth_rejected_on_pop", 32'(aw_acc), 32'(0));
    run_until_idle(60);

    // Reset in the middle of a 4-beat burst from port 1.
    queue_aw(2'd1, 4);
    for (int c = 0; c < 20 && exp_q.size() != 3; c++) cycle();
    chk("mid_rst_progress", 32'(exp_q.size()), 32'(3));
    @(posedge clk_i); #1;
    drive_phase();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("mid_rst_mvalid", 32'(master_valid_o), 32'(0));
    chk("mid_rst_sready", 32'(slave_ready_o), 32'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    clear_model();
    @(negedge clk_i);
    chk("after_rst_mvalid", 32'(master_valid_o), 32'(0));
    chk("after_rst_outstanding", 32'(outstanding_o), 32'(0));
    chk("after_rst_sready", 32'(slave_ready_o), 32'(0));
    for (int c = 0; c < 3; c++) cycle();
    chk("stalled_port1_valid", 32'(slave_valid_i[1]), 32'(1));
    src_q[1].delete();
    queue_aw(2'd1, 2);
    run_until_idle(30);

    // Long burst: 257 beats, last only on the final one.
    queue_aw(2'd2, 257);
    run_until_idle(400);
`ifdef AXI_W_ORDER_SCHED_BEAT_CHECK_EN
    chk("long_burst_err", 32'(err_o), 32'(1));
`else
    chk("long_burst_err", 32'(err_o), 32'(0));
`endif

    // Invalid port index is handshaken, not enqueued, and sets err.
    queue_aw(2'd3, 1);
    for (int c = 0; c < 3; c++) cycle();
    chk("invalid_err", 32'(err_o), 32'(1));
    chk("invalid_outstanding", 32'(outstanding_o), 32'(0));
    chk("invalid_mvalid", 32'(master_valid_o), 32'(0));
    for (int c = 0; c < 2; c++) cycle();
    chk("invalid_err_sticky", 32'(err_o), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
